// File: rtl/source_checker.sv
// Exhaustive sink-side tester for a 4-input combinational block: sweeps all 16
// vectors, holds each for SETTLE_CYC cycles, samples t_in and scores it against EXPECTED.
module source_checker #(
  parameter logic [15:0] EXPECTED   = 16'h4644,
  parameter int          SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        t_in,
  output logic        p,
  output logic        q,
  output logic        r,
  output logic        s,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail,
  output logic        first_fail_vld,
  output logic [15:0] obs_table
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       mismatch;

  assign mismatch = (t_in != EXPECTED[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      {p, q, r, s}   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      obs_table      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Restart from DONE behaves exactly like a fresh start from IDLE.
          if (start) begin
            state          <= SETTLE;
            idx            <= '0;
            cnt            <= '0;
            {p, q, r, s}   <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            obs_table      <= '0;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) state <= SAMPLE;
          else                    cnt   <= cnt + 4'd1;
        end
        SAMPLE: begin
          obs_table[idx] <= t_in;
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (!first_fail_vld) begin
              first_fail     <= idx;
              first_fail_vld <= 1'b1;
            end
          end
          if (idx == 4'hF) begin
            // Last vector: stimulus stays at F; pass folds in this final sample.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 5'd0) && !mismatch;
          end else begin
            state        <= SETTLE;
            idx          <= idx + 4'd1;
            cnt          <= '0;
            {p, q, r, s} <= idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_source_checker.sv
// Scoreboarded random test of source_checker: two instances (SETTLE_CYC 2 and 1)
// driven by behavioural fault models of the function block.
module tb_source_checker;

  localparam logic [15:0] EXP = 16'h4644;

  typedef struct {
    int         d;
    logic [4:0] err;
    logic [3:0] ff;
    logic       ffv;
    logic [15:0] obs;
    logic       pass;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic [1:0] rst, start;
  wire  [1:0] p, q, r, s, busy, done, pass, ffv, t_in;
  wire  [4:0] errc [2];
  wire  [3:0] ff   [2];
  wire  [15:0] obs [2];

  int          mode [2];
  logic [15:0] tbl  [2];
  int          cyc = 0;
  int          tests = 0, fails = 0;
  exp_t        exp_q[$];
  logic [3:0]  seq  [2][64];
  int          seqn [2];
  int          viol [2];
  logic        dprev[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  source_checker #(.EXPECTED(EXP), .SETTLE_CYC(2)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .t_in(t_in[0]),
    .p(p[0]), .q(q[0]), .r(r[0]), .s(s[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(errc[0]), .first_fail(ff[0]),
    .first_fail_vld(ffv[0]), .obs_table(obs[0]));

  source_checker #(.EXPECTED(EXP), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .t_in(t_in[1]),
    .p(p[1]), .q(q[1]), .r(r[1]), .s(s[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(errc[1]), .first_fail(ff[1]),
    .first_fail_vld(ffv[1]), .obs_table(obs[1]));

  // Function-block models: 0 good (rs' + pq'r's), 1 stuck-0, 2 inverted, 3 rs' only, else random table.
  function automatic logic tmodel(int m, logic [15:0] tb, logic [3:0] v);
    logic good;
    good = (v[1] & ~v[0]) | (v[3] & ~v[2] & ~v[1] & v[0]);
    case (m)
      0: return good;
      1: return 1'b0;
      2: return ~good;
      3: return v[1] & ~v[0];
      default: return tb[v];
    endcase
  endfunction

  assign t_in[0] = tmodel(mode[0], tbl[0], {p[0], q[0], r[0], s[0]});
  assign t_in[1] = tmodel(mode[1], tbl[1], {p[1], q[1], r[1], s[1]});

  function automatic int scyc(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic check_done(int d);
    int   hit = -1;
    int   bad = 0;
    exp_t e;
    foreach (exp_q[i]) if (hit < 0 && exp_q[i].d == d) hit = i;
    if (hit < 0) begin
      chk("unexpected_done", 1, 0);
    end else begin
      e = exp_q[hit];
      exp_q.delete(hit);
      chk("done_cycle", cyc, e.done_cyc);
      chk("err_count", errc[d], e.err);
      chk("first_fail_vld", ffv[d], e.ffv);
      if (e.ffv) chk("first_fail", ff[d], e.ff);
      chk("obs_table", obs[d], e.obs);
      chk("pass", pass[d], e.pass);
      chk("stim_final", {p[d], q[d], r[d], s[d]}, 4'hF);
      for (int k = 0; k < seqn[d] && k < 64; k++)
        if (seq[d][k] != 4'(k / (scyc(d) + 1))) bad++;
      chk("stim_sequence", bad, 0);
      chk("busy_cycles", seqn[d], 16 * (scyc(d) + 1));
      chk("busy_done_pass_invariants", viol[d], 0);
    end
    seqn[d] = 0;
    viol[d] = 0;
  endtask

  // Monitor: stimulus trace while busy, invariants every cycle, scoreboard pop on done rise.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        seqn[d]  = 0;
        viol[d]  = 0;
        dprev[d] = 1'b0;
      end else begin
        if (busy[d] && done[d]) viol[d]++;
        if (!done[d] && pass[d]) viol[d]++;
        if (busy[d]) begin
          if (seqn[d] < 64) seq[d][seqn[d]] = {p[d], q[d], r[d], s[d]};
          seqn[d]++;
        end
        if (done[d] && !dprev[d]) check_done(d);
        dprev[d] = done[d];
      end
    end
  end

  // Returns at the negedge following the accepting edge E0.
  task automatic start_sweep(int d, int m);
    exp_t e;
    mode[d] = m;
    tbl[d]  = 16'($urandom);
    e.d = d; e.err = 0; e.ff = 0; e.ffv = 0; e.obs = 0;
    for (int v = 0; v < 16; v++) begin
      e.obs[v] = tmodel(m, tbl[d], 4'(v));
      if (e.obs[v] != EXP[v]) begin
        e.err++;
        if (!e.ffv) begin e.ff = 4'(v); e.ffv = 1'b1; end
      end
    end
    e.pass = (e.err == 0);
    @(negedge clk);
    e.done_cyc = cyc + 1 + 16 * (scyc(d) + 1);
    exp_q.push_back(e);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_done(int d);
    int n = 0;
    while (!done[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done[d], 1'b1);
    @(negedge clk);
  endtask

  task automatic check_reset(int d);
    chk("rst_busy", busy[d], 0);
    chk("rst_done", done[d], 0);
    chk("rst_pass", pass[d], 0);
    chk("rst_stim", {p[d], q[d], r[d], s[d]}, 0);
    chk("rst_err", errc[d], 0);
    chk("rst_ff", {ffv[d], ff[d]}, 0);
    chk("rst_obs", obs[d], 0);
  endtask

  initial begin
    rst = 2'b11; start = 2'b00;
    mode[0] = 0; mode[1] = 0; tbl[0] = '0; tbl[1] = '0;
    #1;
    check_reset(0);
    check_reset(1);
    repeat (2) @(negedge clk);
    rst = 2'b00;

    // Good block, stuck-0, inverted, rs'-only on the short-settle instance.
    start_sweep(0, 0); wait_done(0);
    chk("t1_obs", obs[0], 16'h4644);
    start_sweep(0, 1); wait_done(0);
    chk("t2_err", errc[0], 5); chk("t2_ff", ff[0], 2);
    start_sweep(0, 2); wait_done(0);
    chk("t3_err", errc[0], 16); chk("t3_obs", obs[0], 16'hB9BB);
    start_sweep(1, 3); wait_done(1);
    chk("t4_err", errc[1], 1); chk("t4_ff", ff[1], 9); chk("t4_obs", obs[1], 16'h4444);

    // Start pulse mid-sweep is ignored; start in DONE restarts with cleared stats.
    start_sweep(0, 1);
    repeat (9) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("done_hold", done[0], 1);
    start_sweep(0, 0);
    chk("restart_done", done[0], 0);
    chk("restart_busy", busy[0], 1);
    chk("restart_err", errc[0], 0);
    chk("restart_ffv", ffv[0], 0);
    chk("restart_obs", obs[0], 0);
    wait_done(0);

    // Asynchronous reset mid-cycle, 20 cycles into a sweep.
    start_sweep(0, 2);
    repeat (19) @(negedge clk);
    #2 rst[0] = 1'b1;
    #1 check_reset(0);
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].d == 0) exp_q.delete(i);
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    start_sweep(0, 0); wait_done(0);

    // Random fault models on random instances.
    for (int k = 0; k < 10; k++) begin
      int d;
      d = int'($urandom_range(0, 1));
      start_sweep(d, int'($urandom_range(0, 4)));
      wait_done(d);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
